xaddrgen_sched: RTL and testbench
=================================

// Module: xaddrgen_sched
// PURPOSE
//  Job sequencer for the 6-loop address generator (xaddrgen3). Host pushes complete
//  addrgen configurations ("jobs") into a DEPTH-entry queue. Scheduler pops them in order,
//  drives the config bus, pulses run, waits for done, then starts the next job.
//  Sits between the Versat config registers and one xaddrgen3 instance.
// PARAMETERS
//  ADDR_W    `MEM_ADDR_W (11)  width of start/iterations/shift/incr fields
//  PER_W     `PERIOD_W (10)    width of duty/delay/period fields
//  DEPTH     4                 job queue entries; power of 2, >=2
//  JOB_W     5*PER_W+10*ADDR_W packed job width (derived; do not override)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  en          in   1      1: scheduler may launch queued jobs
//  job_valid   in   1      push request
//  job_ready   out  1      queue not full
//  job_data    in   JOB_W  packed job, field order per `XAGS_* offsets
//  ag_cfg      out  JOB_W  config bus to addrgen (unpacked at instantiation)
//  ag_run      out  1      one-cycle run pulse to addrgen
//  ag_done     in   1      addrgen done
//  busy        out  1      job in flight (state != IDLE)
//  job_done    out  1      one-cycle pulse per completed job
//  level       out  log2(DEPTH)+1  queued job count
//  loop_mode   in   1      replay queue (only with XADDRGEN_SCHED_LOOP_EN)
// BEHAVIOUR
//  Reset: state=IDLE, queue empty, level=0, ag_cfg=0, ag_run=0, busy=0, job_done=0,
//   job_ready=1. Reset mid-job abandons the job; addrgen is reset by its own rst.
//  Push: job_valid&job_ready accepted on the clk edge. job_ready=~full, independent of pops.
//   Push and pop in the same cycle both take effect; level is unchanged.
//  FSM:
//   IDLE : en & level!=0 -> LOAD
//   LOAD : ag_cfg <= head entry -> RUN
//   RUN  : ag_run=1 for this cycle only -> ARM
//   ARM  : ag_done ignored; covers stale done from the previous job -> WAIT
//   WAIT : ag_done=1 -> pop head, job_done=1 for this cycle -> IDLE
//  Latency: en & nonempty sampled at edge t. ag_cfg valid at t+1, ag_run high in t+2,
//   earliest job_done in t+4. Minimum 4 cycles between consecutive ag_run pulses.
//  ag_cfg holds its value from LOAD until the next LOAD; it stays stable the whole time
//   the addrgen runs.
//  en=0 only blocks IDLE->LOAD; a job in flight always completes.
//  Pointers wrap modulo DEPTH; level saturates at DEPTH (push blocked) and 0 (no launch).
//  Pushing while a job runs does not disturb ag_cfg.
// CONFIGURATION
//  XADDRGEN_SCHED_LOOP_EN defined:
//   - loop_mode port exists.
//   - loop_mode=1: WAIT completion advances a play index (0..level-1, wraps to 0)
//     instead of popping; level is unchanged and jobs replay forever.
//   - loop_mode sampled in WAIT only. Dropping it to 0 resumes normal pops from the
//     current play position; earlier entries are discarded.
//  Not defined: no loop_mode port; every completion pops.
// STRUCTURE
//  xversat.vh: MEM_ADDR_W, PERIOD_W, plus new `XAGS_DUTY/DELAY/START/ITER1..INCR3
//   bit offsets and `XAGS_JOB_W. Producers and the unpacker share these.
//  Sub-module xags_fifo: DEPTH x JOB_W sync FIFO with level and peek-at-offset read
//   (offset used by loop mode). FSM and outputs stay in xaddrgen_sched.
// TESTING
//  1 Push 1 job (iter=4, per=1, start=0x10), en=1, model done 4 cyc after run
//    -> ag_run once at t+2, ag_cfg==job, job_done once, level 1->0.
//  2 Push DEPTH jobs with en=0 -> job_ready=0 after 4th push; 5th push ignored, level=4.
//    Then en=1 -> 4 jobs run in push order.
//  3 ag_done held 1 across RUN/ARM -> no early completion; job_done only after done
//    drops and rises again.
//  4 Push during WAIT while level=DEPTH-1 -> level unchanged on the pop cycle,
//    ag_cfg unchanged until next LOAD.
//  5 rst asserted in WAIT -> next cycle all outputs at reset values; queued jobs lost.
//  6 LOOP_EN, 2 jobs, loop_mode=1 for 5 completions -> cfg order A,B,A,B,A; level=2.
//    Clear loop_mode -> B runs, then queue empty.

Source files
------------

// File: rtl/xaddrgen_sched_pkg.sv
// Shared widths, packed-job bit offsets and FSM state type for the addrgen job sequencer.
// Producers and the config unpacker use the XAGS_* offsets, listed LSB first.
package xaddrgen_sched_pkg;

  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned PERIOD_W   = 10;

  localparam int unsigned XAGS_DUTY   = 0;
  localparam int unsigned XAGS_DELAY  = XAGS_DUTY + PERIOD_W;
  localparam int unsigned XAGS_START  = XAGS_DELAY + PERIOD_W;
  localparam int unsigned XAGS_ITER1  = XAGS_START + MEM_ADDR_W;
  localparam int unsigned XAGS_PER1   = XAGS_ITER1 + MEM_ADDR_W;
  localparam int unsigned XAGS_SHIFT1 = XAGS_PER1 + PERIOD_W;
  localparam int unsigned XAGS_INCR1  = XAGS_SHIFT1 + MEM_ADDR_W;
  localparam int unsigned XAGS_ITER2  = XAGS_INCR1 + MEM_ADDR_W;
  localparam int unsigned XAGS_PER2   = XAGS_ITER2 + MEM_ADDR_W;
  localparam int unsigned XAGS_SHIFT2 = XAGS_PER2 + PERIOD_W;
  localparam int unsigned XAGS_INCR2  = XAGS_SHIFT2 + MEM_ADDR_W;
  localparam int unsigned XAGS_ITER3  = XAGS_INCR2 + MEM_ADDR_W;
  localparam int unsigned XAGS_PER3   = XAGS_ITER3 + MEM_ADDR_W;
  localparam int unsigned XAGS_SHIFT3 = XAGS_PER3 + PERIOD_W;
  localparam int unsigned XAGS_INCR3  = XAGS_SHIFT3 + MEM_ADDR_W;
  localparam int unsigned XAGS_JOB_W  = XAGS_INCR3 + MEM_ADDR_W;

  function automatic int unsigned job_width(int unsigned addr_w, int unsigned per_w);
    return 5 * per_w + 10 * addr_w;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StArm,
    StWait
  } sched_state_e;

endpackage

// File: rtl/xaddrgen_sched_if.sv
// Host/addrgen-facing bundle of the job sequencer. loop_mode exists only when
// XADDRGEN_SCHED_LOOP_EN is defined.
interface xaddrgen_sched_if #(
  parameter int unsigned JOB_W = 160,
  parameter int unsigned LVL_W = 3
);

  logic             en;
  logic             job_valid;
  logic             job_ready;
  logic [JOB_W-1:0] job_data;
  logic [JOB_W-1:0] ag_cfg;
  logic             ag_run;
  logic             ag_done;
  logic             busy;
  logic             job_done;
  logic [LVL_W-1:0] level;
`ifdef XADDRGEN_SCHED_LOOP_EN
  logic             loop_mode;

  modport master (
    output en, job_valid, job_data, ag_done, loop_mode,
    input  job_ready, ag_cfg, ag_run, busy, job_done, level
  );

  modport slave (
    input  en, job_valid, job_data, ag_done, loop_mode,
    output job_ready, ag_cfg, ag_run, busy, job_done, level
  );
`else
  modport master (
    output en, job_valid, job_data, ag_done,
    input  job_ready, ag_cfg, ag_run, busy, job_done, level
  );

  modport slave (
    input  en, job_valid, job_data, ag_done,
    output job_ready, ag_cfg, ag_run, busy, job_done, level
  );
`endif

endinterface

// File: rtl/xags_fifo.sv
// DEPTH x WIDTH synchronous job FIFO with occupancy level, multi-entry pop and
// read-at-offset-from-head peek.
module xags_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 160,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [LvlW-1:0]  pop_cnt_i,
  input  logic [PtrW-1:0]  peek_off_i,
  output logic [WIDTH-1:0] peek_data_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [PtrW-1:0]  peek_idx;
  logic             push_ok;

  assign full_o      = (level_q == LvlW'(DEPTH));
  assign push_ok     = push_i & ~full_o;
  assign peek_idx    = rd_ptr_q + peek_off_i;
  assign peek_data_o = mem_q[peek_idx];
  assign level_o     = level_q;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + pop_cnt_i[PtrW-1:0];
    level_d  = level_q + LvlW'(push_ok) - pop_cnt_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/xaddrgen_sched.sv
// Job sequencer for xaddrgen3: queues packed configs, loads, pulses run, waits done.
// Define XADDRGEN_SCHED_LOOP_EN to add loop_mode (replay the queue instead of popping).
module xaddrgen_sched
  import xaddrgen_sched_pkg::*;
#(
  parameter  int unsigned ADDR_W = MEM_ADDR_W,
  parameter  int unsigned PER_W  = PERIOD_W,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned JOB_W  = job_width(ADDR_W, PER_W),
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned LvlW   = PtrW + 1
) (
  input logic              clk,
  input logic              rst,
  xaddrgen_sched_if.slave  bus
);

  sched_state_e     state_q, state_d;
  logic [JOB_W-1:0] cfg_q, cfg_d;
  logic [PtrW-1:0]  play_q, play_d;
  logic [LvlW-1:0]  pop_cnt;
  logic [LvlW-1:0]  level;
  logic [JOB_W-1:0] peek_data;
  logic             full;
  logic             ag_run;
  logic             job_done;

  xags_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (bus.job_valid),
    .push_data_i (bus.job_data),
    .pop_cnt_i   (pop_cnt),
    .peek_off_i  (play_q),
    .peek_data_o (peek_data),
    .level_o     (level),
    .full_o      (full)
  );

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    play_d   = play_q;
    pop_cnt  = '0;
    ag_run   = 1'b0;
    job_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && (level != '0)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        cfg_d   = peek_data;
        state_d = StRun;
      end
      StRun: begin
        ag_run  = 1'b1;
        state_d = StArm;
      end
      // A done still high from the previous job must not complete this one.
      StArm: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.ag_done) begin
          job_done = 1'b1;
          state_d  = StIdle;
`ifdef XADDRGEN_SCHED_LOOP_EN
          if (bus.loop_mode) begin
            if (LvlW'(play_q) + LvlW'(1) >= level) begin
              play_d = '0;
            end else begin
              play_d = play_q + PtrW'(1);
            end
          end else begin
            // Leaving loop mode drops every entry up to and including the one just played.
            pop_cnt = LvlW'(play_q) + LvlW'(1);
            play_d  = '0;
          end
`else
          pop_cnt = LvlW'(play_q) + LvlW'(1);
          play_d  = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      play_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      play_q  <= play_d;
    end
  end

  assign bus.job_ready = ~full;
  assign bus.ag_cfg    = cfg_q;
  assign bus.ag_run    = ag_run;
  assign bus.busy      = (state_q != StIdle);
  assign bus.job_done  = job_done;
  assign bus.level     = level;

endmodule

// File: tb/tb_xaddrgen_sched.sv
// Self-checking bench for xaddrgen_sched: directed table, corner sequences, random traffic
// against a queue-level timing model.
module tb_xaddrgen_sched;
  import xaddrgen_sched_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned JOB_W = XAGS_JOB_W;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef logic [JOB_W-1:0] job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_mode_tb = 1'b0;

  always #5 clk = ~clk;

  xaddrgen_sched_if #(.JOB_W(JOB_W), .LVL_W(LVL_W)) bus ();

`ifdef XADDRGEN_SCHED_LOOP_EN
  assign bus.loop_mode = loop_mode_tb;
`endif

  xaddrgen_sched #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents, replay index, and time since launch.
  job_t mq[$];
  int   m_play     = 0;
  bit   m_inflight = 1'b0;
  int   m_age      = 0;
  job_t m_cfg      = '0;

  task automatic check(input string name, input job_t act, input job_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic job_t rand_job();
    job_t j;
    j = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return j;
  endfunction

  // Check DUT against model for this cycle, then advance both across one clock edge.
  task automatic step();
    bit exp_run, exp_jd, lm, full_before, done_now;
    #1;
    exp_run = m_inflight && (m_age == 1);
    exp_jd  = m_inflight && (m_age >= 3) && bus.ag_done;
    check("ag_run", job_t'(bus.ag_run), job_t'(exp_run));
    check("job_done", job_t'(bus.job_done), job_t'(exp_jd));
    check("busy", job_t'(bus.busy), job_t'(m_inflight));
    check("level", job_t'(bus.level), job_t'(mq.size()));
    check("job_ready", job_t'(bus.job_ready), job_t'(mq.size() < DEPTH));
    check("ag_cfg", bus.ag_cfg, m_cfg);
    @(posedge clk);
`ifdef XADDRGEN_SCHED_LOOP_EN
    lm = loop_mode_tb;
`else
    lm = 1'b0;
`endif
    if (rst) begin
      mq.delete();
      m_play = 0;
      m_inflight = 1'b0;
      m_age = 0;
      m_cfg = '0;
    end else begin
      full_before = (mq.size() >= DEPTH);
      done_now = m_inflight && (m_age >= 3) && bus.ag_done;
      if (m_inflight && m_age == 0) m_cfg = mq[m_play];
      if (done_now) begin
        m_inflight = 1'b0;
        if (lm) begin
          m_play = (m_play + 1 >= mq.size()) ? 0 : m_play + 1;
        end else begin
          for (int k = 0; k <= m_play; k++) void'(mq.pop_front());
          m_play = 0;
        end
      end else if (m_inflight) begin
        m_age++;
      end else if (bus.en && mq.size() > 0) begin
        m_inflight = 1'b1;
        m_age = 0;
      end
      if (bus.job_valid && !full_before) mq.push_back(bus.job_data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_data = '0;
    bus.ag_done = 1'b0;
    loop_mode_tb = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input job_t j);
    bus.job_valid = 1'b1;
    bus.job_data = j;
    step();
    bus.job_valid = 1'b0;
  endtask

  typedef struct {
    logic             valid;
    logic             en;
    logic             done;
    logic             run;
    logic             jd;
    logic             busy;
    logic [LVL_W-1:0] lvl;
    logic             cfg_a;
  } vec_t;

  vec_t tbl[9];
  job_t job_a, job_b, jobs[DEPTH];
  job_t runs[$];
  int   ndone, cyc;
  bit   fin;

  initial begin
    job_a = '0;
    job_a[XAGS_ITER1 +: MEM_ADDR_W] = MEM_ADDR_W'(4);
    job_a[XAGS_PER1 +: PERIOD_W]    = PERIOD_W'(1);
    job_a[XAGS_START +: MEM_ADDR_W] = MEM_ADDR_W'('h10);
    job_b = rand_job();

    //           valid en  done run jd  busy lvl cfg_a
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

    idle_inputs();
    @(negedge clk);
    do_reset();

    // Single job, done four cycles after run.
    for (int i = 0; i < 9; i++) begin
      bus.job_valid = tbl[i].valid;
      bus.job_data = job_a;
      bus.en = tbl[i].en;
      bus.ag_done = tbl[i].done;
      #1;
      check($sformatf("t1_run[%0d]", i), job_t'(bus.ag_run), job_t'(tbl[i].run));
      check($sformatf("t1_jd[%0d]", i), job_t'(bus.job_done), job_t'(tbl[i].jd));
      check($sformatf("t1_busy[%0d]", i), job_t'(bus.busy), job_t'(tbl[i].busy));
      check($sformatf("t1_lvl[%0d]", i), job_t'(bus.level), job_t'(tbl[i].lvl));
      check($sformatf("t1_cfg[%0d]", i), bus.ag_cfg, tbl[i].cfg_a ? job_a : '0);
      step();
    end

    // Fill the queue with en=0; the extra push is dropped; then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      jobs[i] = rand_job();
      push(jobs[i]);
    end
    #1;
    check("t2_ready_full", job_t'(bus.job_ready), '0);
    push(rand_job());
    #1;
    check("t2_level_sat", job_t'(bus.level), job_t'(DEPTH));
    bus.en = 1'b1;
    bus.ag_done = 1'b1;
    runs.delete();
    fin = 1'b0;
    for (cyc = 0; cyc < 80 && !fin; cyc++) begin
      #1;
      if (bus.ag_run) runs.push_back(bus.ag_cfg);
      step();
      fin = (runs.size() == DEPTH) && !bus.busy;
    end
    check("t2_run_count", job_t'(runs.size()), job_t'(DEPTH));
    for (int i = 0; i < DEPTH && i < runs.size(); i++)
      check($sformatf("t2_order[%0d]", i), runs[i], jobs[i]);

    // Stale done across RUN/ARM must not complete the job.
    do_reset();
    push(job_a);
    bus.en = 1'b1;
    bus.ag_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_early_jd[%0d]", i), job_t'(bus.job_done), '0);
      step();
    end
    bus.ag_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t3_wait_jd[%0d]", i), job_t'(bus.job_done), '0);
      step();
    end
    bus.ag_done = 1'b1;
    #1;
    check("t3_jd", job_t'(bus.job_done), job_t'(1));
    step();
    bus.ag_done = 1'b0;

    // Push in the pop cycle while level is DEPTH-1.
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) begin
      jobs[i] = rand_job();
      push(jobs[i]);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.en = 1'b0;
    bus.ag_done = 1'b1;
    push(job_b);
    bus.ag_done = 1'b0;
    #1;
    check("t4_level", job_t'(bus.level), job_t'(DEPTH - 1));
    check("t4_cfg_hold", bus.ag_cfg, jobs[0]);
    step();
    #1;
    check("t4_cfg_hold2", bus.ag_cfg, jobs[0]);

    // Reset in WAIT drops the job in flight and the queue.
    do_reset();
    push(rand_job());
    push(rand_job());
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_level", job_t'(bus.level), '0);
    check("t5_busy", job_t'(bus.busy), '0);
    check("t5_cfg", bus.ag_cfg, '0);
    check("t5_ready", job_t'(bus.job_ready), job_t'(1));
    check("t5_run", job_t'(bus.ag_run), '0);
    for (int i = 0; i < 5; i++) step();

`ifdef XADDRGEN_SCHED_LOOP_EN
    // Replay A,B for five completions, then leave loop mode.
    do_reset();
    push(job_a);
    push(job_b);
    loop_mode_tb = 1'b1;
    bus.en = 1'b1;
    bus.ag_done = 1'b1;
    runs.delete();
    ndone = 0;
    for (cyc = 0; cyc < 120 && ndone < 6; cyc++) begin
      #1;
      if (bus.ag_run) runs.push_back(bus.ag_cfg);
      if (bus.job_done) ndone++;
      step();
      if (ndone == 5 && loop_mode_tb) begin
        #1;
        check("t6_loop_level", job_t'(bus.level), job_t'(2));
        loop_mode_tb = 1'b0;
      end
    end
    check("t6_done_count", job_t'(ndone), job_t'(6));
    check("t6_run_count", job_t'(runs.size()), job_t'(6));
    for (int i = 0; i < 6 && i < runs.size(); i++)
      check($sformatf("t6_order[%0d]", i), runs[i], (i % 2 == 0) ? job_a : job_b);
    for (int i = 0; i < 3; i++) step();
    #1;
    check("t6_empty", job_t'(bus.level), '0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.job_valid = ($urandom_range(1) == 1);
      bus.job_data = rand_job();
      bus.en = ($urandom_range(99) < 85);
      bus.ag_done = ($urandom_range(99) < 30);
      rst = ($urandom_range(399) == 0);
`ifdef XADDRGEN_SCHED_LOOP_EN
      if ($urandom_range(19) == 0) loop_mode_tb = ~loop_mode_tb;
`endif
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
